multicycle_controller: RTL

Multi-cycle sequencer for the RV32I core subset (R-type ALU, I-type ALU, load, store). It replaces single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the same datapath control signals (ALUSrc, Memtoreg, RegWrite, MemRead, MemWrite, ALUOp) plus PC/IR enables, and handshakes with instruction and data memories that may insert wait states. It sits between the IR register and the shared datapath and traps on illegal opcodes or memory timeouts.

---
 rtl/rv_ctrl_pkg.sv | 51 +++++
 rtl/mc_wait_timer.sv | 27 ++
 rtl/multicycle_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, ALUOp codes,
// FSM state, latched instruction class and the datapath control bundle.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b00;
  localparam logic [1:0] ALUOP_ADDR = 2'b01;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CL_R     = 2'd0,
    CL_I     = 2'd1,
    CL_LOAD  = 2'd2,
    CL_STORE = 2'd3
  } class_t;

  typedef struct packed {
    logic       instr_read;
    logic       ir_write;
    logic       pc_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // ALU operation implied by the latched instruction class
  function automatic logic [1:0] class_alu_op(input class_t cls);
    case (cls)
      CL_R:    return ALUOP_R;
      CL_I:    return ALUOP_I;
      default: return ALUOP_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive wait-cycle counter shared by FETCH and MEM; flags the last
// tolerated wait cycle so the controller can trap on the next stall.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer (R/I ALU, load, store) stepping each instruction
// through FETCH/DECODE/EXEC/MEM/WB with memory wait states and trap handling.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        InstrRead,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        Memtoreg,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next;
  class_t      r_class;
  class_t      w_dec_class;
  logic        w_dec_ok;
  logic        w_set_illegal;
  logic        w_set_bus_err;
  logic        w_retire;
  logic        w_wait_en;
  logic        w_wait_clear;
  logic        w_expired;
  ctrl_t       w_ctrl;
  logic        r_illegal;
  logic        r_bus_err;
  logic [31:0] r_instret;

  assign w_wait_en    = ((r_state == ST_FETCH) && !imem_ready) ||
                        ((r_state == ST_MEM)   && !dmem_ready);
  assign w_wait_clear = (w_next != r_state);

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (w_wait_clear),
    .i_en      (w_wait_en),
    .o_expired (w_expired)
  );

  // State and latched class
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_class <= CL_R;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE && w_dec_ok) begin
        r_class <= w_dec_class;
      end
    end
  end

  // Next state; a ready on the last tolerated cycle wins over the timeout
  always_comb begin
    w_next        = r_state;
    w_dec_ok      = 1'b1;
    w_dec_class   = CL_R;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    w_retire      = 1'b0;
    case (Opcode)
      OP_R:     w_dec_class = CL_R;
      OP_I:     w_dec_class = CL_I;
      OP_LOAD:  w_dec_class = CL_LOAD;
      OP_STORE: w_dec_class = CL_STORE;
      default:  w_dec_ok    = 1'b0;
    endcase
    case (r_state)
      ST_FETCH: begin
        if (imem_ready) begin
          w_next = ST_DECODE;
        end else if (w_expired) begin
          w_next        = ST_TRAP;
          w_set_bus_err = 1'b1;
        end
      end
      ST_DECODE: begin
        if (w_dec_ok) begin
          w_next = ST_EXEC;
        end else begin
          w_next        = ST_TRAP;
          w_set_illegal = 1'b1;
        end
      end
      ST_EXEC: begin
        w_next = (r_class == CL_LOAD || r_class == CL_STORE) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (r_class == CL_LOAD) begin
            w_next = ST_WB;
          end else begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_expired) begin
          w_next        = ST_TRAP;
          w_set_bus_err = 1'b1;
        end
      end
      ST_WB: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
  end

  // Control outputs from state and class; forced quiet while reset is held
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.instr_read = 1'b1;
        w_ctrl.ir_write   = imem_ready;
        w_ctrl.pc_write   = imem_ready;
      end
      ST_EXEC: begin
        w_ctrl.alu_src = (r_class != CL_R);
        w_ctrl.alu_op  = class_alu_op(r_class);
      end
      ST_MEM: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALUOP_ADDR;
        w_ctrl.mem_read  = (r_class == CL_LOAD);
        w_ctrl.mem_write = (r_class == CL_STORE);
      end
      ST_WB: begin
        w_ctrl.alu_src    = (r_class != CL_R);
        w_ctrl.alu_op     = class_alu_op(r_class);
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = (r_class == CL_LOAD);
      end
      default: w_ctrl = '0;
    endcase
    if (reset) begin
      w_ctrl = '0;
    end
  end

  // Sticky trap flags and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_retire)      r_instret <= r_instret + 32'd1;
    end
  end

  assign InstrRead = w_ctrl.instr_read;
  assign IRWrite   = w_ctrl.ir_write;
  assign PCWrite   = w_ctrl.pc_write;
  assign ALUSrc    = w_ctrl.alu_src;
  assign ALUOp     = w_ctrl.alu_op;
  assign MemRead   = w_ctrl.mem_read;
  assign MemWrite  = w_ctrl.mem_write;
  assign RegWrite  = w_ctrl.reg_write;
  assign Memtoreg  = w_ctrl.mem_to_reg;
  assign illegal   = r_illegal;
  assign bus_err   = r_bus_err;
  assign instret   = r_instret;

endmodule
